// File: rtl/frame_write_if.sv
// Stream-in / camera-out bundle for frame_write: AXI-Stream byte sink plus parallel camera bus.
// slave = frame_write side, master = source/observer side.
interface frame_write_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] D;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready, PCLK, VSYNC, HREF, D
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready, PCLK, VSYNC, HREF, D
  );
endinterface

// File: rtl/frame_write.sv
// Camera emulator: replays an AXI-Stream byte frame as PCLK/VSYNC/HREF/D; bus changes only on PCLK fall.
// Byte lands on D at the slot edge it is accepted; source is pulled once per slot, never stalls timing.
module frame_write #(
  parameter int H_BYTES   = 1280,
  parameter int V_LINES   = 480,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         init_done,
  frame_write_if.slave cam,
  output logic         frame_done,
  output logic         underflow,
  output logic         tlast_err
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LINE_LEN    = H_BYTES + H_BLANK;
  localparam int FRAME_BYTES = H_BYTES * V_LINES;
  localparam int V_MAX       = imax(imax(VS_LINES, VBP_LINES), imax(V_LINES, VFP_LINES));
  localparam int HW          = $clog2(LINE_LEN + 1);
  localparam int VW          = $clog2(V_MAX + 1);
  localparam int SW          = $clog2(FRAME_BYTES + 1);

  localparam logic [HW-1:0] COL_LINE_END = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] COL_ACT_END  = HW'(H_BYTES - 1);
  localparam logic [VW-1:0] VS_END       = VW'(VS_LINES - 1);
  localparam logic [VW-1:0] VBP_END      = VW'(VBP_LINES - 1);
  localparam logic [VW-1:0] ACT_END      = VW'(V_LINES - 1);
  localparam logic [VW-1:0] VFP_END      = VW'(VFP_LINES - 1);
  localparam logic [SW-1:0] LAST_SLOT    = SW'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_HBLANK,
    S_VFP
  } state_t;

  state_t        state_q, state_n;
  logic [HW-1:0] col_q, col_n;
  logic [VW-1:0] line_q, line_n;
  logic [SW-1:0] slot_q;
  logic          pclk_q;
  logic [7:0]    d_q;
  logic          done_n;
  logic          line_end;
  logic          load_slot;
  logic          is_last_slot;

  // Every decision is taken on the clk edge where PCLK falls (pclk_q == 1 before the edge).
  always_comb begin
    state_n  = state_q;
    col_n    = col_q;
    line_n   = line_q;
    done_n   = 1'b0;
    line_end = (col_q == COL_LINE_END);

    if (pclk_q) begin
      if (state_q != S_IDLE) begin
        col_n = line_end ? '0 : col_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (init_done && cam.s_tvalid) begin
            state_n = S_VSYNC;
            col_n   = '0;
            line_n  = '0;
          end
        end

        S_VSYNC: begin
          if (line_end) begin
            if (line_q == VS_END) begin
              state_n = S_VBP;
              line_n  = '0;
            end else begin
              line_n = line_q + 1'b1;
            end
          end
        end

        S_VBP: begin
          if (line_end) begin
            if (line_q == VBP_END) begin
              state_n = S_ACTIVE;
              line_n  = '0;
            end else begin
              line_n = line_q + 1'b1;
            end
          end
        end

        S_ACTIVE: begin
          if (col_q == COL_ACT_END) begin
            state_n = S_HBLANK;
          end
        end

        // line_q counts active lines here, so the last blanking interval leads into VFP.
        S_HBLANK: begin
          if (line_end) begin
            if (line_q == ACT_END) begin
              state_n = S_VFP;
              line_n  = '0;
            end else begin
              state_n = S_ACTIVE;
              line_n  = line_q + 1'b1;
            end
          end
        end

        S_VFP: begin
          if (line_end) begin
            if (line_q == VFP_END) begin
              state_n = S_IDLE;
              line_n  = '0;
              done_n  = 1'b1;
            end else begin
              line_n = line_q + 1'b1;
            end
          end
        end

        default: begin
          state_n = S_IDLE;
          col_n   = '0;
          line_n  = '0;
        end
      endcase
    end
  end

  // Ready is raised in the PCLK-high clk that precedes the edge opening a byte slot.
  assign load_slot    = pclk_q && (state_n == S_ACTIVE);
  assign is_last_slot = (slot_q == LAST_SLOT);

  assign cam.s_tready = load_slot && !RESET;
  assign cam.PCLK     = pclk_q;
  assign cam.VSYNC    = (state_q == S_VSYNC);
  assign cam.HREF     = (state_q == S_ACTIVE);
  assign cam.D        = d_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      slot_q     <= '0;
      pclk_q     <= 1'b0;
      d_q        <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      tlast_err  <= 1'b0;
    end else begin
      pclk_q     <= ~pclk_q;
      state_q    <= state_n;
      col_q      <= col_n;
      line_q     <= line_n;
      frame_done <= done_n;

      if (pclk_q) begin
        if (load_slot) begin
          slot_q <= slot_q + 1'b1;
          if (cam.s_tvalid) begin
            d_q <= cam.s_tdata;
            if (cam.s_tlast != is_last_slot) begin
              tlast_err <= 1'b1;
            end
          end else begin
            // Empty slot keeps its place in the line; the bus idles at zero.
            d_q       <= '0;
            underflow <= 1'b1;
          end
        end else begin
          d_q <= '0;
          if (state_n == S_IDLE) begin
            slot_q <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_write.sv
// Bench for frame_write: random/directed stream source, frame-position reference model, per-cycle compare.
module tb_frame_write;
  localparam int H    = 4;
  localparam int VL   = 2;
  localparam int HB   = 2;
  localparam int VS   = 1;
  localparam int VBP  = 1;
  localparam int VFP  = 1;
  localparam int LINE = H + HB;
  localparam int FT   = (VS + VBP + VL + VFP) * LINE;
  localparam int FB   = H * VL;

  logic clk       = 1'b0;
  logic RESET     = 1'b1;
  logic init_done = 1'b0;
  logic frame_done;
  logic underflow;
  logic tlast_err;

  frame_write_if bus();

  frame_write #(
    .H_BYTES  (H),
    .V_LINES  (VL),
    .H_BLANK  (HB),
    .VS_LINES (VS),
    .VBP_LINES(VBP),
    .VFP_LINES(VFP)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .init_done (init_done),
    .cam       (bus),
    .frame_done(frame_done),
    .underflow (underflow),
    .tlast_err (tlast_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame position p counts PCLK periods from the edge VSYNC rises; -1 means idle.
  function automatic bit slot_at(input int p);
    int al;
    if (p < 0) return 1'b0;
    al = p / LINE - VS - VBP;
    return (al >= 0) && (al < VL) && ((p % LINE) < H);
  endfunction

  function automatic bit vs_at(input int p);
    return (p >= 0) && ((p / LINE) < VS);
  endfunction

  function automatic int slot_idx(input int p);
    return (p / LINE - VS - VBP) * H + (p % LINE);
  endfunction

  int         m_pos   = -1;
  bit         m_pclk  = 1'b0;
  logic [7:0] m_d     = 8'h00;
  bit         m_under = 1'b0;
  bit         m_terr  = 1'b0;
  bit         m_done  = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (RESET) begin
        m_pclk = 1'b0; m_pos = -1; m_d = 8'h00;
        m_under = 1'b0; m_terr = 1'b0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_pclk) begin
          if (m_pos == FT - 1) begin
            m_pos  = -1;
            m_done = 1'b1;
          end else if (m_pos >= 0) begin
            m_pos = m_pos + 1;
          end else if (init_done && bus.s_tvalid) begin
            m_pos = 0;
          end
          if (slot_at(m_pos)) begin
            if (bus.s_tvalid) begin
              m_d = bus.s_tdata;
              if (bus.s_tlast != (slot_idx(m_pos) == FB - 1)) m_terr = 1'b1;
            end else begin
              m_d     = 8'h00;
              m_under = 1'b1;
            end
          end else begin
            m_d = 8'h00;
          end
        end
        m_pclk = !m_pclk;
      end
    end
  end

  // Stream source: byte choice is made per slot, as announced by s_tready.
  bit src_en     = 1'b1;
  bit rnd        = 1'b0;
  int drop_slot  = -1;
  int tlast_slot = FB - 1;
  int drv_slot   = 0;

  initial begin
    bit         v;
    bit         tl;
    logic [7:0] dat;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = 8'h00;
    bus.s_tlast  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (RESET) drv_slot = 0;
      if (bus.s_tready) begin
        if (rnd) begin
          v   = ($urandom_range(0, 9) != 0);
          dat = 8'($urandom_range(0, 255));
          tl  = (drv_slot == FB - 1) ^ ($urandom_range(0, 15) == 0);
        end else begin
          v   = (drv_slot != drop_slot);
          dat = 8'(drv_slot + 1);
          tl  = (drv_slot == tlast_slot);
        end
        bus.s_tvalid = v;
        bus.s_tdata  = dat;
        bus.s_tlast  = tl;
        drv_slot = (drv_slot == FB - 1) ? 0 : drv_slot + 1;
      end else begin
        bus.s_tvalid = src_en;
        bus.s_tdata  = 8'hA5;
        bus.s_tlast  = 1'b0;
      end
    end
  end

  // Compare against the model and gather event counts, mid-cycle.
  int         cyc = 0, n_done = 0, n_ready = 0, href_rise = 0, vs_cnt = 0;
  int         vs_fall_cyc = 0, done_delta = 0;
  bit         vs_prev = 1'b0, href_prev = 1'b0;
  logic [7:0] cap[$];

  initial begin
    int  np;
    bit  exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      np      = (m_pos >= 0 && m_pos < FT - 1) ? m_pos + 1 : -1;
      exp_rdy = m_pclk && !RESET && slot_at(np);
      chk("PCLK", int'(bus.PCLK), int'(m_pclk));
      chk("VSYNC", int'(bus.VSYNC), int'(vs_at(m_pos)));
      chk("HREF", int'(bus.HREF), int'(slot_at(m_pos)));
      chk("D", int'(bus.D), int'(m_d));
      chk("s_tready", int'(bus.s_tready), int'(exp_rdy));
      chk("frame_done", int'(frame_done), int'(m_done));
      chk("underflow", int'(underflow), int'(m_under));
      chk("tlast_err", int'(tlast_err), int'(m_terr));

      if (frame_done) begin
        n_done++;
        done_delta = cyc - vs_fall_cyc;
      end
      if (bus.s_tready) n_ready++;
      if (bus.PCLK && bus.HREF) cap.push_back(bus.D);
      if (vs_prev && !bus.VSYNC) vs_fall_cyc = cyc;
      if (bus.VSYNC) vs_cnt++;
      if (bus.HREF && !href_prev) href_rise++;
      vs_prev   = bus.VSYNC;
      href_prev = bus.HREF;
    end
  end

  int         s_done, s_ready, s_href, s_vs, s_cap;
  logic [7:0] exp_a[FB];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_done  = n_done;
    s_ready = n_ready;
    s_href  = href_rise;
    s_vs    = vs_cnt;
    s_cap   = cap.size();
  endtask

  task automatic run_frames(input int n);
    int got = 0;
    for (int c = 0; c < 200 * n && got < n; c++) begin
      @(posedge clk); #1;
      if (frame_done) got++;
    end
    chk("frames before timeout", got, n);
  endtask

  task automatic chk_cap(input string nm);
    chk({nm, " byte count"}, cap.size() - s_cap, FB);
    for (int i = 0; i < FB; i++) begin
      if (s_cap + i < cap.size())
        chk($sformatf("%s byte%0d", nm, i), int'(cap[s_cap + i]), int'(exp_a[i]));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " PCLK"}, int'(bus.PCLK), 0);
    chk({nm, " VSYNC"}, int'(bus.VSYNC), 0);
    chk({nm, " HREF"}, int'(bus.HREF), 0);
    chk({nm, " D"}, int'(bus.D), 0);
    chk({nm, " s_tready"}, int'(bus.s_tready), 0);
    chk({nm, " frame_done"}, int'(frame_done), 0);
    chk({nm, " underflow"}, int'(underflow), 0);
    chk({nm, " tlast_err"}, int'(tlast_err), 0);
  endtask

  task automatic single_frame(input string nm);
    snap();
    init_done = 1'b1;
    tick(2);
    chk({nm, " VSYNC at first fall"}, int'(bus.VSYNC), 1);
    init_done = 1'b0;            // dropping enable mid-frame must not abort it
    run_frames(1);
    tick(2);
    chk({nm, " frame_done pulses"}, n_done - s_done, 1);
    chk({nm, " ready count"}, n_ready - s_ready, FB);
    chk({nm, " HREF bursts"}, href_rise - s_href, VL);
    // VBP + 2 active + VFP = 4 lines of 6 PCLK = 24 PCLK = 48 clk after VSYNC falls
    chk({nm, " VSYNC fall to done clks"}, done_delta, 48);
    chk_cap(nm);
  endtask

  initial begin
    RESET = 1'b1;
    init_done = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    RESET = 1'b0;

    // Enable low: valid data waiting must not start a frame.
    snap();
    tick(20);
    chk("idle ready count", n_ready - s_ready, 0);
    chk("idle VSYNC cycles", vs_cnt - s_vs, 0);
    chk("idle HREF bursts", href_rise - s_href, 0);

    for (int i = 0; i < FB; i++) exp_a[i] = 8'(i + 1);
    single_frame("clean");
    chk("clean underflow", int'(underflow), 0);
    chk("clean tlast_err", int'(tlast_err), 0);

    drop_slot = 2;
    exp_a[2]  = 8'h00;
    single_frame("gap");
    chk("gap underflow", int'(underflow), 1);
    chk("gap tlast_err", int'(tlast_err), 0);

    drop_slot  = -1;
    tlast_slot = 3;
    exp_a[2]   = 8'h03;
    single_frame("badlast");
    chk("badlast tlast_err", int'(tlast_err), 1);
    chk("badlast underflow sticky", int'(underflow), 1);

    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    chk("flags cleared underflow", int'(underflow), 0);
    chk("flags cleared tlast_err", int'(tlast_err), 0);

    // Reset while line 2 is being sent.
    tlast_slot = FB - 1;
    snap();
    init_done = 1'b1;
    for (int c = 0; c < 300 && (href_rise - s_href) < 2; c++) tick(1);
    chk("reached line 2", int'((href_rise - s_href) >= 2), 1);
    RESET = 1'b1;
    tick(1);
    chk_reset_outputs("midframe reset");
    tick(1);
    RESET = 1'b0;

    snap();
    run_frames(4);
    init_done = 1'b0;
    tick(4);
    chk("b2b frame_done pulses", n_done - s_done, 4);
    chk("b2b ready count", n_ready - s_ready, 4 * FB);
    chk("b2b underflow", int'(underflow), 0);
    chk("b2b tlast_err", int'(tlast_err), 0);

    rnd = 1'b1;
    snap();
    init_done = 1'b1;
    run_frames(5);
    init_done = 1'b0;
    tick(4);
    chk("random frame_done pulses", n_done - s_done, 5);
    chk("random ready count", n_ready - s_ready, 5 * FB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
